// File: rtl/sev_seg_pkg.sv
// Shared display geometry and arbiter state encoding for the seven-segment path.
// Word width is digit width times digit count; the arbiter only ever moves whole words.
package sev_seg_pkg;

    localparam int DIGIT_W  = 4;
    localparam int N_DIGITS = 8;
    localparam int DIN_W    = DIGIT_W * N_DIGITS;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after last_grant_i, wrapping N-1 -> 0. Purely combinational.
// any_o flags a valid pick; gnt_o is one-hot (all-zero when nothing requests).
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        // Scan starts one past the previous winner so it is visited last.
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(last_grant_i) + i) % N);
            if (!any_o && req_i[cand]) begin
                any_o     = 1'b1;
                gnt_idx_o = cand;
            end
        end
        if (any_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/sev_seg_arbiter.sv
// Round-robin share of the 8-digit display between N_REQ requesters; each granted word dwells DWELL_CYC cycles.
// Optional SSEG_ARB_PRIO0_EN: requester 0 may preempt another owner's dwell without disturbing RR order.
module sev_seg_arbiter
    import sev_seg_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DWELL_CYC = 100_000_000,
    localparam int IDX_W     = $clog2(N_REQ)
) (
    input  logic                   CLK100MHZ,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*DIN_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [DIN_W-1:0]       disp_din,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy
);

    localparam int CNT_W = $clog2(DWELL_CYC + 1);

    arb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIN_W-1:0] disp_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_q;
    logic             busy_q;

    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [DIN_W-1:0] req_words [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_words[i] = req_data[i*DIN_W +: DIN_W];
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx),
        .any_o        (gnt_any)
    );

`ifdef SSEG_ARB_PRIO0_EN
    logic preempt;
    assign preempt = (state_q == SHOW) && (owner_q != '0) && req_valid[0];
`endif

    always_comb begin
        req_ready = '0;
        if (!rst) begin
            if (state_q == IDLE) begin
                req_ready = gnt;
            end
`ifdef SSEG_ARB_PRIO0_EN
            else if (preempt) begin
                req_ready[0] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            disp_q  <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        disp_q  <= req_words[gnt_idx];
                        owner_q <= gnt_idx;
                        last_q  <= gnt_idx;
                        cnt_q   <= CNT_W'(DWELL_CYC - 1);
                        busy_q  <= 1'b1;
                        state_q <= SHOW;
                    end
                end
                SHOW: begin
`ifdef SSEG_ARB_PRIO0_EN
                    // last_q is deliberately left alone so the RR rotation resumes where it was.
                    if (preempt) begin
                        disp_q  <= req_words[0];
                        owner_q <= '0;
                        cnt_q   <= CNT_W'(DWELL_CYC - 1);
                    end else
`endif
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign disp_din = disp_q;
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sev_seg_arbiter.sv
// Directed bench for sev_seg_arbiter (N_REQ=4, DWELL_CYC=8); expected grants queued at drive time.
// A monitor pops one expectation per observed transfer and checks the registered display afterwards.
module tb_sev_seg_arbiter;

    localparam int N     = 4;
    localparam int DWELL = 8;

    typedef struct {
        int          idx;
        logic [31:0] dat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [31:0]    disp_din;
    logic [1:0]     owner;
    logic           busy;

    int   checks   = 0;
    int   failures = 0;
    int   n_acc    = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   acc_cyc[$];

    sev_seg_arbiter #(
        .N_REQ     (N),
        .DWELL_CYC (DWELL)
    ) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .disp_din  (disp_din),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] d);
        req_valid[i]         = v;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic expect_acc(input int idx, input logic [31:0] dat);
        exp_t e;
        e.idx = idx;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int c;
        c = 0;
        while (n_acc < target && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        chk("accept_timeout", 32'(n_acc >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic count_busy(output int bc);
        bc = 0;
        while (busy && bc < 20) begin
            bc++;
            @(posedge clk); #2;
        end
    endtask

    // Transfer monitor: one queued expectation per valid&ready cycle.
    initial begin
        exp_t       e;
        logic [3:0] rdy_s;
        forever begin
            @(negedge clk);
            if (!rst && (req_valid & req_ready) != '0) begin
                rdy_s = req_ready;
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", {28'd0, rdy_s}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ready_onehot", {28'd0, rdy_s}, 32'(4'b0001 << e.idx));
                    acc_cyc.push_back(cyc);
                    @(posedge clk); #1;
                    chk("disp_din", disp_din, e.dat);
                    chk("owner", {30'd0, owner}, 32'(e.idx));
                    chk("busy_after_accept", {31'd0, busy}, 32'd1);
                    n_acc++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        int          fair_ord [5];
        logic [3:0]  fair_mask;
        logic [31:0] word_a;

`ifdef SSEG_ARB_PRIO0_EN
        fair_mask = 4'b1110;
        fair_ord  = '{1, 2, 3, 1, 2};
`else
        fair_mask = 4'b1111;
        fair_ord  = '{0, 1, 2, 3, 0};
`endif
        word_a = 32'hA5A5_0000;

        // Reset with every requester valid: nothing may be accepted.
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) drive(i, 1'b1, 32'hC0DE_0000 + 32'(i) * 32'h0101);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready", {28'd0, req_ready}, 32'd0);
        chk("reset_disp", disp_din, 32'd0);
        chk("reset_owner", {30'd0, owner}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Fairness with all participants held valid; accepts must be DWELL+1 apart.
        for (int i = 0; i < N; i++) req_valid[i] = fair_mask[i];
        for (int k = 0; k < 5; k++) expect_acc(fair_ord[k], 32'hC0DE_0000 + 32'(fair_ord[k]) * 32'h0101);
        rst = 1'b0;
        wait_acc(5, 80);
        if (acc_cyc.size() >= 5) begin
            for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(DWELL + 1));
        end
        req_valid = '0;
        wait_idle(20);

        // Single requester: word held for exactly DWELL busy cycles.
        expect_acc(2, 32'hDEAD_BEEF);
        drive(2, 1'b1, 32'hDEAD_BEEF);
        wait_acc(6, 20);
        drive(2, 1'b0, 32'h0);
        count_busy(bc);
        chk("dwell_len", 32'(bc), 32'(DWELL));

        // Reset mid-dwell, then req0 must beat req2 (RR would otherwise pick 2 after 1).
        expect_acc(1, 32'hB0B0_0001);
        drive(1, 1'b1, 32'hB0B0_0001);
        wait_acc(7, 20);
        drive(1, 1'b0, 32'h0);
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b1;
        drive(0, 1'b1, word_a);
        drive(2, 1'b1, 32'h2222_2222);
        expect_acc(0, word_a);
        @(posedge clk); #2;
        chk("midreset_disp", disp_din, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_owner", {30'd0, owner}, 32'd0);
        chk("midreset_ready", {28'd0, req_ready}, 32'd0);
        rst = 1'b0;
        wait_acc(8, 20);
        drive(0, 1'b0, 32'h0);
        drive(2, 1'b0, 32'h0);

        // Requester 1 offers during SHOW then withdraws: no transfer, display unchanged.
        @(posedge clk); #2;
        drive(1, 1'b1, 32'hBAD0_BAD0);
        repeat (2) begin @(posedge clk); #2; end
        drive(1, 1'b0, 32'h0);
        wait_idle(20);
        repeat (3) begin @(posedge clk); #2; end
        chk("withdraw_no_xfer", 32'(n_acc), 32'd8);
        chk("withdraw_disp", disp_din, word_a);
        chk("withdraw_owner", {30'd0, owner}, 32'd0);

        // Owner 3 mid-dwell, req0 arrives with 0x123.
        expect_acc(3, 32'h3333_0003);
        drive(3, 1'b1, 32'h3333_0003);
        wait_acc(9, 20);
        drive(3, 1'b0, 32'h0);
        repeat (2) begin @(posedge clk); #2; end
        expect_acc(0, 32'h0000_0123);
        drive(0, 1'b1, 32'h0000_0123);
        #2;
`ifdef SSEG_ARB_PRIO0_EN
        chk("prio0_ready", {28'd0, req_ready}, 32'd1);
        wait_acc(10, 5);
`else
        chk("prio0_ready", {28'd0, req_ready}, 32'd0);
        wait_acc(10, 20);
`endif
        drive(0, 1'b0, 32'h0);
        count_busy(bc);
        chk("dwell_after_req0", 32'(bc), 32'(DWELL));

        // Next RR winner with req0 and req1 valid reveals whether last_grant moved.
`ifdef SSEG_ARB_PRIO0_EN
        expect_acc(0, 32'hE000_0000);
`else
        expect_acc(1, 32'hE000_0001);
`endif
        drive(0, 1'b1, 32'hE000_0000);
        drive(1, 1'b1, 32'hE000_0001);
        wait_acc(11, 20);
        req_valid = '0;
        wait_idle(20);
        repeat (2) begin @(posedge clk); #2; end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
